sd_interp_upsampler: RTL and testbench

//   Linear-interpolating upsampler feeding the first-order sigma-delta modulator.

---
 rtl/sd_interp_upsampler.sv | 117 +++++++++++
 tb/tb_sd_interp_upsampler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sd_interp_upsampler.sv
// Linear-interpolating upsampler: buffers PCM samples in a 2-entry FIFO and ramps
// dout from one sample to the next over 2**LOG2_OSR clocks, feeding the sigma-delta modulator.
module sd_interp_upsampler #(
    parameter int N        = 16,
    parameter int LOG2_OSR = 6
) (
    input  logic         clk,
    input  logic         areset,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [N-1:0] dout,
    output logic         underflow,
    output logic         running
);
    localparam int AW = N + LOG2_OSR + 1;
    localparam logic [LOG2_OSR-1:0] PH_LAST = '1;

    typedef enum logic [1:0] {IDLE, RUN, STARVE} state_t;
    state_t state, state_nxt;

    logic [N-1:0] fifo_mem [2];
    logic         rd_ptr, wr_ptr;
    logic [1:0]   count;
    logic         push, pop, starve;
    logic [N-1:0] head;

    logic signed [N-1:0]  prev, cur;
    logic signed [N:0]    delta;
    logic signed [AW-1:0] delta_ext, cur_sh, acc;
    logic [LOG2_OSR-1:0]  ph;

    assign din_ready = (count != 2'd2);
    assign push      = din_valid && din_ready;
    assign head      = fifo_mem[rd_ptr];
    assign running   = (state == RUN);

    // delta spans the full N+1-bit range, so a full-scale step cannot wrap
    assign delta     = $signed({cur[N-1], cur}) - $signed({prev[N-1], prev});
    assign delta_ext = {{LOG2_OSR{delta[N]}}, delta};
    assign cur_sh    = {cur[N-1], cur, {LOG2_OSR{1'b0}}};
    assign dout      = N'(acc >>> LOG2_OSR);

    always_ff @(posedge clk) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        starve    = 1'b0;
        case (state)
            IDLE, STARVE: begin
                if (count != 2'd0) begin
                    pop       = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (ph == PH_LAST) begin
                    if (count != 2'd0) begin
                        pop = 1'b1;
                    end else begin
                        starve    = 1'b1;
                        state_nxt = STARVE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pop decisions use the registered count, so a same-cycle push is never popped
    always_ff @(posedge clk) begin
        if (areset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            prev      <= '0;
            cur       <= '0;
            acc       <= '0;
            ph        <= '0;
            underflow <= 1'b0;
        end else begin
            underflow <= starve;
            if (state == RUN) begin
                acc <= acc + delta_ext;
                if (ph != PH_LAST) ph <= ph + LOG2_OSR'(1);
            end
            if (pop) begin
                prev <= cur;
                cur  <= head;
                ph   <= '0;
                // Entering from IDLE/STARVE the ramp restarts at the held sample
                if (state != RUN) acc <= cur_sh;
            end
        end
    end
endmodule

// File: tb/tb_sd_interp_upsampler.sv
// Directed bench for sd_interp_upsampler (N=16, LOG2_OSR=2): reset, ramps, rounding,
// backpressure, underflow/resume, full-scale step and mid-ramp reset.
module tb_sd_interp_upsampler;
    logic        clk = 1'b0;
    logic        areset;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] dout;
    logic        underflow;
    logic        running;

    int n_cmp = 0;
    int n_err = 0;

    sd_interp_upsampler #(.N(16), .LOG2_OSR(2)) dut (
        .clk(clk), .areset(areset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .underflow(underflow), .running(running)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        areset = 1'b1; din_valid = 1'b0; din = '0;
        tick; tick;
        areset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++; if (dout !== 16'd0) begin n_err++; $display("FAIL reset_dout: got %0d want 0", $signed(dout)); end
        n_cmp++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", din_ready); end
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", running); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    endtask

    task automatic test_basic_ramp;
        do_reset;
        din = 16'd400; din_valid = 1'b1; tick; din_valid = 1'b0;
        tick;
        n_cmp++; if (dout !== 16'd0 || running !== 1'b1) begin n_err++; $display("FAIL ramp_start: got %0d/%b want 0/1", $signed(dout), running); end
        din = 16'd800; din_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick; din_valid = 1'b0;
            n_cmp++; if (dout !== 16'(i * 100)) begin n_err++; $display("FAIL ramp_%0d: got %0d want %0d", i, $signed(dout), i * 100); end
        end
    endtask

    task automatic test_floor_rounding;
        int pos_exp[5] = '{0, 0, 1, 2, 3};
        int neg_exp[5] = '{0, -1, -1, -1, -1};
        do_reset;
        din = 16'd3; din_valid = 1'b1; tick; din_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_cmp++; if (dout !== 16'(pos_exp[i])) begin n_err++; $display("FAIL floor_pos_%0d: got %0d want %0d", i, $signed(dout), pos_exp[i]); end
        end
        do_reset;
        din = 16'hFFFF; din_valid = 1'b1; tick; din_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_cmp++; if (dout !== 16'(neg_exp[i])) begin n_err++; $display("FAIL floor_neg_%0d: got %0d want %0d", i, $signed(dout), neg_exp[i]); end
        end
    endtask

    task automatic test_backpressure;
        int   smp[4]    = '{10, 20, 30, 40};
        int   exp_d[18] = '{0, 0, 2, 5, 7, 10, 12, 15, 17, 20, 22, 25, 27, 30, 32, 35, 37, 40};
        bit   exp_r[18] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        int   idx = 0;
        logic rdy;
        do_reset;
        for (int k = 0; k < 18; k++) begin
            din = 16'(smp[(idx < 4) ? idx : 3]);
            din_valid = (idx < 4);
            rdy = din_ready;
            tick;
            if (din_valid && rdy) idx++;
            n_cmp++; if (dout !== 16'(exp_d[k])) begin n_err++; $display("FAIL bp_dout_%0d: got %0d want %0d", k, $signed(dout), exp_d[k]); end
            n_cmp++; if (din_ready !== exp_r[k]) begin n_err++; $display("FAIL bp_ready_%0d: got %b want %b", k, din_ready, exp_r[k]); end
        end
        din_valid = 1'b0;
        n_cmp++; if (idx != 4) begin n_err++; $display("FAIL bp_accepted: got %0d want 4", idx); end
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL bp_underflow: got %b want 1", underflow); end
    endtask

    task automatic test_underflow_resume;
        int ramp[4]   = '{100, 200, 300, 400};
        int resume[4] = '{200, 0, -200, -400};
        do_reset;
        din = 16'd400; din_valid = 1'b1; tick; din_valid = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_cmp++; if (dout !== 16'(ramp[i])) begin n_err++; $display("FAIL uf_ramp_%0d: got %0d want %0d", i, $signed(dout), ramp[i]); end
            n_cmp++; if (underflow !== (i == 3)) begin n_err++; $display("FAIL uf_pulse_%0d: got %b want %b", i, underflow, (i == 3)); end
        end
        tick;
        n_cmp++; if (underflow !== 1'b0 || dout !== 16'd400) begin n_err++; $display("FAIL uf_hold: got %b/%0d want 0/400", underflow, $signed(dout)); end
        tick; tick;
        n_cmp++; if (running !== 1'b0 || dout !== 16'd400) begin n_err++; $display("FAIL uf_starve: got %b/%0d want 0/400", running, $signed(dout)); end
        din = 16'(-400); din_valid = 1'b1; tick; din_valid = 1'b0;
        tick;
        n_cmp++; if (dout !== 16'd400 || running !== 1'b1) begin n_err++; $display("FAIL uf_restart: got %0d/%b want 400/1", $signed(dout), running); end
        for (int i = 0; i < 4; i++) begin
            tick;
            n_cmp++; if (dout !== 16'(resume[i])) begin n_err++; $display("FAIL uf_resume_%0d: got %0d want %0d", i, $signed(dout), resume[i]); end
        end
    endtask

    task automatic test_full_scale_reset;
        int fs[4] = '{16383, -1, -16385, -32768};
        do_reset;
        din = 16'd32767; din_valid = 1'b1; tick;
        din = 16'h8000; tick; din_valid = 1'b0;
        tick; tick; tick; tick;
        n_cmp++; if (dout !== 16'd32767) begin n_err++; $display("FAIL fs_top: got %0d want 32767", $signed(dout)); end
        for (int i = 0; i < 4; i++) begin
            tick;
            n_cmp++; if (dout !== 16'(fs[i])) begin n_err++; $display("FAIL fs_step_%0d: got %0d want %0d", i, $signed(dout), fs[i]); end
        end
        // Ramp toward 100 with 200 buffered, then reset mid-ramp
        din = 16'd100; din_valid = 1'b1; tick;
        din = 16'd200; tick; din_valid = 1'b0;
        tick;
        areset = 1'b1; tick; areset = 1'b0;
        n_cmp++; if (dout !== 16'd0 || running !== 1'b0) begin n_err++; $display("FAIL mid_reset: got %0d/%b want 0/0", $signed(dout), running); end
        n_cmp++; if (din_ready !== 1'b1 || underflow !== 1'b0) begin n_err++; $display("FAIL mid_reset_flags: got %b/%b want 1/0", din_ready, underflow); end
        tick; tick;
        n_cmp++; if (running !== 1'b0 || dout !== 16'd0) begin n_err++; $display("FAIL mid_reset_empty: got %b/%0d want 0/0", running, $signed(dout)); end
        din = 16'd4; din_valid = 1'b1; tick; din_valid = 1'b0;
        tick;
        n_cmp++; if (dout !== 16'd0) begin n_err++; $display("FAIL post_reset_start: got %0d want 0", $signed(dout)); end
        tick;
        n_cmp++; if (dout !== 16'd1) begin n_err++; $display("FAIL post_reset_step: got %0d want 1", $signed(dout)); end
    endtask

    initial begin
        areset = 1'b1; din = '0; din_valid = 1'b0;
        test_reset;
        test_basic_ramp;
        test_floor_rounding;
        test_backpressure;
        test_underflow_resume;
        test_full_scale_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
